power_alu_sequencer: RTL and testbench
======================================

// Module: power_alu_sequencer
// PURPOSE
//  Command sequencer in front of the 8-bit accumulator ALU (PowerALU). Buffers
//  {opcode, operand} commands from a valid/ready requester and issues them one
//  at a time to the ALU. Holds the accumulator stable while idle. Returns each
//  post-op accumulator value on a valid/ready result port.
// PARAMETERS
//  DEPTH    4  command FIFO entries (power of 2, >=2)
//  ALU_LAT  1  clk edges from ALU input change to alu_b update (>=1)
// PORTS
//  clk         in   1  clock, all logic rising-edge
//  rst         in   1  synchronous reset, active-high
//  in_valid    in   1  command present
//  in_ready    out  1  FIFO can accept (= !full)
//  in_opcode   in   4  ALU opcode 0000..1111 (ALU encoding)
//  in_operand  in   8  signed operand A
//  res_valid   out  1  result present
//  res_ready   in   1  result consumer ready
//  res_data    out  8  accumulator after op
//  res_opcode  out  4  opcode that produced res_data
//  busy        out  1  state!=IDLE or FIFO non-empty
//  alu_opcode  out  4  to ALU opcode
//  alu_a       out  8  to ALU a
//  alu_b       in   8  from ALU b (accumulator)
//  ovf         out  1  signed overflow flag (only with PALU_SEQ_OVF_EN)
// BEHAVIOUR
//  Reset (rst=1 at edge): FIFO flushed, state=INIT, res_valid=0, res_data=0,
//   res_opcode=0, ovf=0. in_ready=0 during INIT.
//  FSM: INIT -> IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   INIT:  1 cycle. Drive alu_opcode=0000, alu_a=0 (clear acc). Go to IDLE.
//   IDLE:  Drive alu_opcode=0000, alu_a=alu_b (transfer-self = hold).
//          If FIFO non-empty: pop head, go to ISSUE.
//   ISSUE: 1 cycle. Drive the popped opcode/operand. Latch opcode and
//          pre-op alu_b. Go to WAIT.
//   WAIT:  Hold alu_opcode=0000, alu_a=alu_b. Count ALU_LAT-1 further cycles,
//          then capture alu_b into res_data. Go to RESP.
//   RESP:  res_valid=1, res_data/res_opcode stable until res_ready=1 at edge.
//          At that edge, go to IDLE.
//  Only one command is outstanding at a time. Issue-to-res_valid = ALU_LAT+1
//   cycles. Back-to-back throughput is one op per ALU_LAT+3 cycles.
//  FIFO: push when in_valid&&in_ready. Pop only in IDLE. A push and a pop in
//   the same cycle are both performed, and the count is unchanged. A push
//   while full is impossible (in_ready=0). Pointers wrap modulo DEPTH.
//  While the sequencer is in RESP with res_ready=0, the FIFO keeps accepting
//   until full. Total accepted = DEPTH+1 (one in flight).
//  Operand/result are 8-bit two's complement with wrap (no saturation).
//  rst in any state aborts the op. The in-flight result is discarded, never
//   emitted.
// CONFIGURATION
//  PALU_SEQ_OVF_EN defined: ovf is registered in WAIT alongside res_data.
//   ovf=1 on signed overflow, else 0:
//   - 0001 INC: pre==127
//   - 0100 DEC: pre==-128
//   - 0010 ADD: sign(pre)==sign(op) != sign(res)
//   - 0011 SUB: sign(pre)!=sign(op) and sign(res)!=sign(pre)
//   - every other opcode: 0
//   ovf is valid with res_valid and held with it.
//  Not defined: ovf tied to 0, no overflow logic synthesized.
// TESTING
//  1 Reset then release -> one cycle of alu_opcode=0000/alu_a=0x00; alu_b=0x00;
//    res_valid=0; in_ready=1 from the 2nd cycle after release.
//  2 Push {0000,0x0A} then {0010,0xF1}, res_ready=1 -> res_data 0x0A (op 0000),
//    then 0xFB (op 0010). Each res_valid exactly ALU_LAT+1 cycles after issue.
//  3 res_ready=0, push continuously -> 5 commands accepted (DEPTH=4), then
//    in_ready=0. Raise res_ready -> remaining 4 results drain in FIFO order.
//  4 Idle 20 cycles after result 0x37 -> alu_b stays 0x37; busy=0.
//  5 OVF_EN: load {0000,0x7F} then {0001,0x00} -> res 0x80, ovf=1.
//    {0011,0x01} on acc 0x80 -> res 0x7F, ovf=1. {0010,0x01} on 0x05 -> 0x06, ovf=0.
//  6 rst asserted during WAIT with 2 queued -> res_valid never rises. FIFO
//    empty, INIT clears acc to 0x00, busy=0 after INIT.

Source files
------------

// File: rtl/power_alu_sequencer.sv
// Command sequencer for the 8-bit accumulator ALU: FIFO-buffered, one op in flight.
// Define PALU_SEQ_OVF_EN to register a signed-overflow flag with each result.
module power_alu_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_opcode,
  input  logic [7:0] in_operand,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_opcode,
  output logic       busy,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [11:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [3:0]    op_q;
  logic [7:0]    opr_q;
  logic [CW-1:0] lat_q;
  logic [7:0]    res_data_q;
  logic [3:0]    res_op_q;

  logic empty, full, push, pop, cap;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign in_ready  = !full && (state_q != S_INIT);
  assign push      = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign res_valid = (state_q == S_RESP);
  assign res_data  = res_data_q;
  assign res_opcode = res_op_q;

  // Outside ISSUE the ALU transfers its own value back: the hold command.
  always_comb begin
    state_d    = state_q;
    alu_opcode = 4'h0;
    alu_a      = alu_b;
    pop        = 1'b0;
    cap        = 1'b0;
    unique case (state_q)
      S_INIT: begin
        alu_a   = 8'h00;
        state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_opcode = op_q;
        alu_a      = opr_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == CW'(ALU_LAT - 1)) begin
          cap     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      res_data_q <= 8'h00;
      res_op_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (state_q == S_WAIT && !cap) lat_q <= lat_q + 1'b1;
      else                           lat_q <= '0;
      if (cap) begin
        res_data_q <= alu_b;
        res_op_q   <= op_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {in_opcode, in_operand};
    if (pop)  {op_q, opr_q} <= mem_q[rd_q];
  end

`ifdef PALU_SEQ_OVF_EN
  logic [7:0] pre_q;
  logic       ovf_q, ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    unique case (1'b1)
      (op_q == 4'h1): ovf_d = (pre_q == 8'h7F);
      (op_q == 4'h4): ovf_d = (pre_q == 8'h80);
      (op_q == 4'h2): ovf_d = (pre_q[7] == opr_q[7]) &&
                              (alu_b[7] != pre_q[7]);
      (op_q == 4'h3): ovf_d = (pre_q[7] != opr_q[7]) &&
                              (alu_b[7] != pre_q[7]);
      default:        ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) pre_q <= alu_b;
      if (cap)                ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_power_alu_sequencer.sv
// Bench for power_alu_sequencer: ALU stand-in, transaction scoreboard,
// directed scenarios plus randomized traffic.
module tb_power_alu_sequencer;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;
`ifdef PALU_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_opcode = 4'h0;
  logic [7:0] in_operand = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic [3:0] res_opcode;
  logic       busy;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b = 8'h5A;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bit rr_rand = 1'b0;
  bit rr_fix  = 1'b0;

  logic [11:0] q [$];
  logic [7:0]  acc_m;
  logic [11:0] h;
  logic [7:0]  er;
  logic        eo;
  logic        pv = 1'b0;
  logic        pr = 1'b0;

  power_alu_sequencer #(.DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand(in_operand),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_opcode(res_opcode),
    .busy(busy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Signed-integer view of the accumulator ALU.
  function automatic int alu_int(input logic [3:0] op,
                                 input logic [7:0] a,
                                 input logic [7:0] acc);
    int sa, sc;
    sa = $signed(a);
    sc = $signed(acc);
    case (op)
      4'h0:    return sa;
      4'h1:    return sc + 1;
      4'h2:    return sc + sa;
      4'h3:    return sc - sa;
      4'h4:    return sc - 1;
      4'h5:    return int'(acc & a);
      4'h6:    return int'(acc | a);
      4'h7:    return int'(acc ^ a);
      default: return sc;
    endcase
  endfunction

  function automatic logic [7:0] ref_res(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] acc);
    int r;
    r = alu_int(op, a, acc);
    return r[7:0];
  endfunction

  function automatic logic ref_ovf(input logic [3:0] op,
                                   input logic [7:0] a,
                                   input logic [7:0] acc);
    int r;
    r = alu_int(op, a, acc);
    if (!OVF_EN || op == 4'h0 || op > 4'h4) return 1'b0;
    return (r > 127) || (r < -128);
  endfunction

  // ALU stand-in, one edge of latency.
  always @(posedge clk)
    alu_b <= ref_res(alu_opcode, alu_a, alu_b);

  always @(posedge clk) begin
    #1;
    res_ready = rr_rand ? ($urandom_range(0, 1) == 1) : rr_fix;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: commands in order, accumulator tracked per consumed result.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_m = 8'h00;
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) check("rv_hold", res_valid, 1);
      if (res_valid) begin
        if (q.size() == 0) begin
          check("spurious", res_valid, 0);
        end else begin
          h  = q[0];
          er = ref_res(h[11:8], h[7:0], acc_m);
          eo = ref_ovf(h[11:8], h[7:0], acc_m);
          check("res_data", res_data, er);
          check("res_op", res_opcode, h[11:8]);
          check("ovf", ovf, eo);
          if (res_ready) begin
            acc_m = er;
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back({in_opcode, in_operand});
      pv = res_valid;
      pr = res_ready;
    end
  end

  task automatic push(input logic [3:0] op, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_opcode  = op;
    in_operand = d;
    in_valid   = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("push_ok", ok, 1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (!busy && !res_valid && q.size() == 0) break;
    end
    check("drain_busy", busy, 0);
    check("drain_q", q.size(), 0);
  endtask

  initial begin
    int gap, n_acc, bad, rv_seen;
    bit got;

    // Reset and INIT
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_op", alu_opcode, 4'h0);
    check("init_a", alu_a, 8'h00);
    check("init_rv", res_valid, 0);
    check("init_rdy", in_ready, 0);
    check("init_rd", res_data, 8'h00);
    check("init_ro", res_opcode, 4'h0);
    check("init_ovf", ovf, 0);
    @(posedge clk);
    #1;
    check("idle_b", alu_b, 8'h00);
    check("idle_rdy", in_ready, 1);
    check("idle_busy", busy, 0);

    // Two commands, latency and throughput
    rr_fix = 1'b1;
    push(4'h0, 8'h0A);
    push(4'h2, 8'hF1);
    check("iss_op", alu_opcode, 4'h0);
    check("iss_a", alu_a, 8'h0A);
    check("iss_rv", res_valid, 0);
    @(posedge clk);
    #1;
    check("wait_rv", res_valid, 0);
    @(posedge clk);
    #1;
    check("resp_rv", res_valid, 1);
    check("resp_d", res_data, 8'h0A);
    gap = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        gap = k;
        break;
      end
    end
    check("b2b_gap", gap, LAT + 3);
    check("second_d", res_data, 8'hFB);
    wait_idle();

    // Backpressure: DEPTH + 1 accepted
    rr_fix = 1'b0;
    @(posedge clk);
    #1;
    n_acc = 0;
    in_opcode  = 4'($urandom_range(0, 15));
    in_operand = 8'($urandom);
    in_valid   = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) begin
        n_acc++;
        in_opcode  = 4'($urandom_range(0, 15));
        in_operand = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("accepted", n_acc, DEPTH + 1);
    check("full_rdy", in_ready, 0);
    rr_fix = 1'b1;
    wait_idle();

    // Accumulator held while idle
    push(4'h0, 8'h37);
    wait_idle();
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (alu_b != 8'h37 || busy) bad++;
    end
    check("idle_hold", bad, 0);
    check("idle_acc", alu_b, 8'h37);

    // Overflow corners
    push(4'h0, 8'h7F);
    push(4'h1, 8'h00);
    push(4'h3, 8'h01);
    push(4'h0, 8'h05);
    push(4'h2, 8'h01);
    push(4'h0, 8'h80);
    push(4'h4, 8'h00);
    push(4'h2, 8'h80);
    wait_idle();
    check("ovf_acc", alu_b, 8'hFF);

    // Reset during WAIT with two queued
    push(4'h0, 8'h11);
    push(4'h2, 8'h22);
    push(4'h3, 8'h33);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_rv", res_valid, 0);
    check("rst_rdy", in_ready, 0);
    @(posedge clk);
    #1;
    check("rst_acc", alu_b, 8'h00);
    check("rst_busy", busy, 0);
    rv_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (res_valid || busy) rv_seen++;
    end
    check("rst_quiet", rv_seen, 0);

    // Randomized traffic with random backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push(4'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end
    rr_rand = 1'b0;
    rr_fix  = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
